fu_ctrl: RTL and testbench
==========================

FU_CTRL -- requirements
Module: fu_ctrl

Interface
REQ-001 The module SHALL use these parameters (name, default, meaning):
- DBITS, 32, operand/result width.
- MC_CYCLES, 32, cycles spent in RUN for iterative operations.

REQ-002 The module SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_aluop  in  1  write of WB value to aluop register (x29); launches an operation.
- wr_op1  in  1  write of WB value to op1 register (x30).
- wr_op2  in  1  write of WB value to op2 register (x31).
- wr_data  in  DBITS  WB value for the above writes.
- rd_op3  in  1  DE is reading result register (x27) via SW.
- rd_csr  in  1  DE is reading status register (x26) via SW.
- op3  out  DBITS  result register.
- csr  out  3  status: [0] busy, [1] done, [2] error.
- stall_rd  out  1  DE must stall: result read requested while busy.

Function
REQ-003 op1/op2 SHALL be internal DBITS registers.
- Written on any edge where wr_op1/wr_op2 is high, in every state.
- The written value is visible on the following cycle.

REQ-004 Opcode SHALL be wr_data[2:0] at launch:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (single-cycle).
- 5 MUL: low DBITS of unsigned product, shift-add; iterative.
- 6 DIVU: unsigned quotient, restoring division; iterative.
- 7 illegal.

REQ-005 Launch SHALL occur on an edge with wr_aluop=1 while state is IDLE or DONE.
- Operands are snapshotted from op1/op2 as held before that edge.
- A same-edge wr_op1/wr_op2 affects only later launches.

REQ-006 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE/DONE --launch single-cycle--> DONE; op3 is updated at the launch edge.
- IDLE/DONE --launch MUL/DIVU--> RUN; counter loaded with MC_CYCLES-1.
- RUN: counter decrements each edge. At the edge where counter==0, op3 <= result and next state is DONE.
- DONE --rd_op3 (no launch)--> IDLE.
- Launch takes priority over rd_op3 on the same edge.

REQ-007 Single-cycle latency SHALL be 1: op3 and csr[1] are valid in the cycle after the launch edge.
- Iterative latency SHALL be MC_CYCLES+... precisely: csr[0]=1 for exactly MC_CYCLES cycles after the launch edge; op3 and csr[1] are valid after launch edge + MC_CYCLES.

REQ-008 Status bits:
- csr[0] SHALL be 1 iff state==RUN.
- csr[1] SHALL be 1 iff state==DONE.

REQ-009 op3 SHALL hold its last value in all states except at a result-write edge.
- While RUN, partial results SHALL NOT appear on op3.

REQ-010 Illegal opcode (7) SHALL:
- go to DONE;
- leave op3 unchanged;
- set csr[2].

REQ-011 DIVU with op2==0 SHALL:
- complete in the normal RUN duration;
- write op3 = all ones;
- set csr[2].

REQ-012 wr_aluop while RUN SHALL:
- be ignored (no restart, operands untouched);
- set csr[2].

REQ-013 csr[2] SHALL be sticky.
- Cleared on an edge with rd_csr=1, or on any successful launch.
- A set condition on the same edge as a clear wins.

REQ-014 stall_rd SHALL be combinational: rd_op3 & (state==RUN).
- rd_op3 in IDLE or DONE SHALL NOT stall.
- rd_op3 in IDLE returns the previous op3.

REQ-015 All arithmetic SHALL be modulo 2^DBITS; SUB wraps.

Reset
REQ-016 On any edge with reset=1, the following SHALL be cleared, overriding all other inputs:
- state=IDLE, counter=0, op1=op2=op3=0, csr=3'b000, error=0.

REQ-017 Reset asserted during RUN SHALL abort the operation with no op3 update.

REQ-018 stall_rd SHALL be 0 in the cycle after a reset edge.

Verification
REQ-019 Single-cycle op: op1=7, op2=5, launch SUB -> next cycle op3=2, csr=3'b010; rd_op3 -> csr=3'b000 next cycle.

REQ-020 MUL: op1=0x0001_0003, op2=0x0000_0010, launch MUL.
- csr[0]=1 for exactly 32 cycles.
- Then op3=0x0010_0030, csr=3'b010.
- rd_op3 during RUN drives stall_rd=1 each cycle.

REQ-021 DIVU: op1=100, op2=7 -> op3=14 after 32 cycles.
- Repeat with op2=0 -> op3=0xFFFF_FFFF, csr=3'b110.
- rd_csr -> csr[2]=0.

REQ-022 Overlap: launch MUL, then at RUN cycle 10 write aluop=ADD and op1=9.
- MUL completes unaltered; csr[2]=1.
- A following ADD launch uses op1=9.

REQ-023 Illegal and reset: launch opcode 7 -> csr=3'b110, op3 unchanged.
- Launch DIVU, assert reset at cycle 5 -> all outputs 0, no later result write.

REQ-024 Same-edge: in DONE, assert wr_aluop(ADD) with rd_op3.
- State stays DONE with the new result.
- Same-edge wr_op1 with launch uses the old op1.

Source files
------------

// File: rtl/fu_ctrl.sv
// fu_ctrl: memory-mapped functional-unit controller.
//
// Operand registers op1/op2 and the opcode register are written through WB
// side-band strobes. A write to the opcode register launches the operation.
// ADD/SUB/AND/OR/XOR finish in one cycle. MUL (shift-add) and DIVU
// (restoring division) iterate in RUN for MC_CYCLES cycles.
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   reset     - synchronous, active-high reset
//   wr_aluop  - WB write of the opcode register (x29); launches an operation
//   wr_op1    - WB write of operand 1 (x30)
//   wr_op2    - WB write of operand 2 (x31)
//   wr_data   - WB value for the writes above
//   rd_op3    - DE reads the result register (x27)
//   rd_csr    - DE reads the status register (x26)
//   op3       - result register
//   csr       - status: [0] busy, [1] done, [2] sticky error
//   stall_rd  - DE must stall: result read while busy
//
// MC_CYCLES is expected to be >= DBITS. Iterations run only on the first
// DBITS RUN edges, and extra RUN edges simply hold the finished value.

module fu_ctrl #(
    parameter int DBITS     = 32,
    parameter int MC_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_aluop,
    input  logic             wr_op1,
    input  logic             wr_op2,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rd_op3,
    input  logic             rd_csr,
    output logic [DBITS-1:0] op3,
    output logic [2:0]       csr,
    output logic             stall_rd
);

    localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIVU = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q;
    logic [DBITS-1:0] op1_q, op2_q, op3_q;
    logic             err_q, err_n;
    logic             is_div_q;
    logic             dz_q;

    // Iteration registers shared by MUL and DIVU:
    //   MUL : acc = partial product, a = shifted multiplicand, b = multiplier
    //   DIVU: acc = partial remainder, a = dividend/quotient, b = divisor
    logic [DBITS:0]   acc_q, acc_n;
    logic [DBITS-1:0] a_q, a_n;
    logic [DBITS-1:0] b_q, b_n;
    logic [DBITS:0]   rem_sh, diff;

    logic [2:0]       opc;
    logic             launch;
    logic             iter_op;
    logic             step_en;
    logic [DBITS-1:0] mul_res, div_res;

    function automatic logic [DBITS-1:0] alu_single(input logic [2:0]       op,
                                                    input logic [DBITS-1:0] a,
                                                    input logic [DBITS-1:0] b);
        logic [DBITS-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    assign opc     = wr_data[2:0];
    assign launch  = wr_aluop && (state_q != RUN);
    assign iter_op = (opc == OP_MUL) || (opc == OP_DIVU);

    // Only the first DBITS RUN edges perform an iteration step.
    assign step_en = (MC_CYCLES <= DBITS) || (int'(cnt_q) >= (MC_CYCLES - DBITS));

    // ---- iteration step ----
    always_comb begin
        acc_n  = acc_q;
        a_n    = a_q;
        b_n    = b_q;
        rem_sh = {acc_q[DBITS-1:0], a_q[DBITS-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (step_en) begin
            if (is_div_q) begin
                // Restoring step: keep the subtraction only if it did not borrow.
                if (!diff[DBITS]) begin
                    acc_n = diff;
                    a_n   = {a_q[DBITS-2:0], 1'b1};
                end else begin
                    acc_n = rem_sh;
                    a_n   = {a_q[DBITS-2:0], 1'b0};
                end
            end else begin
                if (b_q[0]) begin
                    acc_n = acc_q + {1'b0, a_q};
                end
                a_n = {a_q[DBITS-2:0], 1'b0};
                b_n = {1'b0, b_q[DBITS-1:1]};
            end
        end
    end

    // The last step is folded into the completion edge, so results use *_n.
    assign mul_res = acc_n[DBITS-1:0];
    assign div_res = dz_q ? {DBITS{1'b1}} : a_n;

    // ---- next state / error flag ----
    always_comb begin
        logic err_set;
        logic err_clr;
        state_n = state_q;
        err_set = 1'b0;
        err_clr = rd_csr;
        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    if (opc == OP_ILL) begin
                        state_n = DONE;
                        err_set = 1'b1;
                    end else begin
                        state_n = iter_op ? RUN : DONE;
                        err_clr = 1'b1;
                    end
                end else if ((state_q == DONE) && rd_op3) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (wr_aluop) begin
                    err_set = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_n = DONE;
                    if (is_div_q && dz_q) begin
                        err_set = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // A set on the same edge as a clear wins.
        if (err_set) begin
            err_n = 1'b1;
        end else if (err_clr) begin
            err_n = 1'b0;
        end else begin
            err_n = err_q;
        end
    end

    // ---- registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            op3_q    <= '0;
            err_q    <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q <= state_n;
            err_q   <= err_n;
            if (wr_op1) begin
                op1_q <= wr_data;
            end
            if (wr_op2) begin
                op2_q <= wr_data;
            end
            if (state_q == RUN) begin
                acc_q <= acc_n;
                a_q   <= a_n;
                b_q   <= b_n;
                if (cnt_q == '0) begin
                    op3_q <= is_div_q ? div_res : mul_res;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end else if (launch) begin
                // Operands come from op1_q/op2_q as held before this edge.
                if (iter_op) begin
                    cnt_q    <= CW'(MC_CYCLES - 1);
                    acc_q    <= '0;
                    a_q      <= op1_q;
                    b_q      <= op2_q;
                    is_div_q <= (opc == OP_DIVU);
                    dz_q     <= (opc == OP_DIVU) && (op2_q == '0);
                end else if (opc != OP_ILL) begin
                    op3_q <= alu_single(opc, op1_q, op2_q);
                end
            end
        end
    end

    assign op3      = op3_q;
    assign csr      = {err_q, state_q == DONE, state_q == RUN};
    assign stall_rd = rd_op3 && (state_q == RUN);

endmodule

// File: tb/tb_fu_ctrl.sv
// tb_fu_ctrl: directed scenarios plus randomized traffic for fu_ctrl, all
// checked every cycle against a transaction-level reference model.

module tb_fu_ctrl;

    localparam int DBITS = 32;
    localparam int MC    = 32;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_aluop, wr_op1, wr_op2;
    logic [DBITS-1:0] wr_data;
    logic             rd_op3, rd_csr;
    logic [DBITS-1:0] op3;
    logic [2:0]       csr;
    logic             stall_rd;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [31:0] m_op1, m_op2, m_op3, m_pend;
    bit          m_err, m_dz;
    int          m_mode, m_left;

    fu_ctrl #(.DBITS(DBITS), .MC_CYCLES(MC)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_aluop (wr_aluop),
        .wr_op1   (wr_op1),
        .wr_op2   (wr_op2),
        .wr_data  (wr_data),
        .rd_op3   (rd_op3),
        .rd_csr   (rd_csr),
        .op3      (op3),
        .csr      (csr),
        .stall_rd (stall_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_op1 = 0; m_op2 = 0; m_op3 = 0; m_pend = 0;
        m_err = 0; m_dz = 0; m_mode = M_IDLE; m_left = 0;
    endtask

    task automatic model_step(input bit a, input bit w1, input bit w2, input logic [31:0] d,
                              input bit r3, input bit rc, input bit rs);
        bit eset, eclr;
        logic [2:0] opc;
        if (rs) begin
            model_reset();
            return;
        end
        eset = 0;
        eclr = rc;
        opc  = d[2:0];
        if (m_mode == M_RUN) begin
            if (a) eset = 1;
            m_left--;
            if (m_left == 0) begin
                m_op3  = m_pend;
                m_mode = M_DONE;
                if (m_dz) eset = 1;
            end
        end else if (a) begin
            if (opc == 3'd7) begin
                eset   = 1;
                m_mode = M_DONE;
            end else begin
                eclr   = 1;
                m_mode = M_DONE;
                case (opc)
                    3'd0: m_op3 = m_op1 + m_op2;
                    3'd1: m_op3 = m_op1 - m_op2;
                    3'd2: m_op3 = m_op1 & m_op2;
                    3'd3: m_op3 = m_op1 | m_op2;
                    3'd4: m_op3 = m_op1 ^ m_op2;
                    3'd5: begin
                        m_pend = m_op1 * m_op2;
                        m_dz   = 0;
                        m_mode = M_RUN;
                        m_left = MC;
                    end
                    default: begin
                        m_dz   = (m_op2 == 0);
                        m_pend = m_dz ? 32'hFFFF_FFFF : m_op1 / m_op2;
                        m_mode = M_RUN;
                        m_left = MC;
                    end
                endcase
            end
        end else if (m_mode == M_DONE && r3) begin
            m_mode = M_IDLE;
        end
        if (eset) m_err = 1;
        else if (eclr) m_err = 0;
        if (w1) m_op1 = d;
        if (w2) m_op2 = d;
    endtask

    // One clock cycle: drive, compare against model, clock, advance model.
    task automatic cyc(input bit a, input bit w1, input bit w2, input logic [31:0] d,
                       input bit r3, input bit rc, input bit rs);
        @(negedge clk);
        wr_aluop = a; wr_op1 = w1; wr_op2 = w2; wr_data = d;
        rd_op3 = r3; rd_csr = rc; reset = rs;
        #1;
        check("op3", op3, m_op3);
        check("csr", {29'b0, csr}, {29'b0, m_err, m_mode == M_DONE, m_mode == M_RUN});
        check("stall", {31'b0, stall_rd}, {31'b0, r3 && (m_mode == M_RUN)});
        @(posedge clk);
        model_step(a, w1, w2, d, r3, rc, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int busy;
        logic [31:0] d;
        reset = 1; wr_aluop = 0; wr_op1 = 0; wr_op2 = 0; wr_data = 0;
        rd_op3 = 0; rd_csr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_op3", op3, 0);
        check("rst_csr", {29'b0, csr}, 0);

        // SUB 7-5
        cyc(0, 1, 0, 7, 0, 0, 0);
        cyc(0, 0, 1, 5, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        #2;
        check("sub_op3", op3, 2);
        check("sub_csr", {29'b0, csr}, 3'b010);
        cyc(0, 0, 0, 0, 1, 0, 0);
        #2;
        check("rd_csr_idle", {29'b0, csr}, 3'b000);

        // MUL with stall reads during RUN
        cyc(0, 1, 0, 32'h0001_0003, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0010, 0, 0, 0);
        cyc(1, 0, 0, 5, 0, 0, 0);
        busy = 0;
        #2;
        if (csr[0]) busy++;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0, 0, i < 32, 0, 0);
            #2;
            if (csr[0]) busy++;
        end
        check("mul_busy_cycles", busy, MC);
        check("mul_op3", op3, 32'h0010_0030);
        check("mul_csr", {29'b0, csr}, 3'b010);

        // DIVU 100/7, then divide by zero
        cyc(0, 1, 0, 100, 0, 0, 0);
        cyc(0, 0, 1, 7, 0, 0, 0);
        cyc(1, 0, 0, 6, 0, 0, 0);
        idle(MC);
        #2;
        check("divu_op3", op3, 14);
        check("divu_csr", {29'b0, csr}, 3'b010);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 6, 0, 0, 0);
        idle(MC - 1);
        #2;
        check("div0_busy", {31'b0, csr[0]}, 1);
        idle(1);
        #2;
        check("div0_op3", op3, 32'hFFFF_FFFF);
        check("div0_csr", {29'b0, csr}, 3'b110);
        cyc(0, 0, 0, 0, 0, 1, 0);
        #2;
        check("rdcsr_clr", {29'b0, csr}, 3'b010);

        // Overlap: launch and op1 write during RUN
        cyc(0, 1, 0, 3, 0, 0, 0);
        cyc(0, 0, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 5, 0, 0, 0);
        idle(10);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 9, 0, 0, 0);
        idle(20);
        #2;
        check("ovl_op3", op3, 12);
        check("ovl_csr", {29'b0, csr}, 3'b110);
        cyc(1, 0, 0, 0, 0, 0, 0);
        #2;
        check("ovl_add_op3", op3, 13);
        check("ovl_add_csr", {29'b0, csr}, 3'b010);

        // Illegal opcode
        cyc(1, 0, 0, 7, 0, 0, 0);
        #2;
        check("ill_op3", op3, 13);
        check("ill_csr", {29'b0, csr}, 3'b110);

        // Same-edge launch + rd_op3 + wr_op1 in DONE
        cyc(0, 1, 0, 20, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0);
        #2;
        check("same_op3", op3, 24);
        check("same_csr", {29'b0, csr}, 3'b010);
        cyc(1, 0, 0, 0, 0, 0, 0);
        #2;
        check("same_new_op1", op3, 4);

        // Reset during DIVU
        cyc(0, 1, 0, 50, 0, 0, 0);
        cyc(1, 0, 0, 6, 0, 0, 0);
        idle(5);
        cyc(0, 0, 0, 0, 0, 0, 1);
        #2;
        check("rstrun_op3", op3, 0);
        check("rstrun_csr", {29'b0, csr}, 0);
        rd_op3 = 1;
        #1;
        check("rstrun_stall", {31'b0, stall_rd}, 0);
        idle(40);
        #2;
        check("rstrun_nowrite", op3, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit a, w1, w2, r3, rc, rs;
            a  = ($urandom_range(0, 7) == 0);
            w1 = ($urandom_range(0, 3) == 0);
            w2 = ($urandom_range(0, 3) == 0);
            r3 = ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = $urandom_range(0, 15);
                default: d = $urandom;
            endcase
            cyc(a, w1, w2, d, r3, rc, rs);
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
